mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port 16-bit data/instruction memory among three requesters: data port
//  (LOAD/STOR from the control FSM), instruction fetch, and display read-out. Fixed priority
//  data > fetch > display, with an anti-starvation boost for display. Sits between the
//  processor datapath/control and the memory block. One access in flight at a time.
// PARAMETERS
//  AW          16  address width
//  DW          16  data width
//  RD_LAT       1  memory read latency in cycles, range 0..7 (0 = combinational read)
//  STARVE_MAX   4  number of lost arbitrations after which display wins, range 1..15
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   reset, asynchronous, active-high
//  d_req      in   1   data-port request (level)
//  d_we       in   1   data-port write enable (1 = STOR, 0 = LOAD)
//  d_addr     in   AW  data-port address
//  d_wdata    in   DW  data-port write data
//  d_ack      out  1   data-port done pulse
//  f_req      in   1   fetch request, read-only
//  f_addr     in   AW  fetch address
//  f_ack      out  1   fetch done pulse
//  v_req      in   1   display request, read-only
//  v_addr     in   AW  display address
//  v_ack      out  1   display done pulse
//  rdata      out  DW  read data, valid in the cycle any *_ack is high for a read
//  mem_addr   out  AW  memory address
//  mem_we     out  1   memory write strobe
//  mem_wdata  out  DW  memory write data
//  mem_rdata  in   DW  memory read data
//  busy       out  1   access in progress (state != IDLE)
//  gnt_id     out  2   current or last grant: 0 = none, 1 = data, 2 = fetch, 3 = display
// BEHAVIOUR
//  Reset: state = IDLE. All outputs are 0, including mem_addr, mem_wdata, rdata and gnt_id.
//   starve_cnt = 0. Reset is asynchronous, so mem_we drops immediately; an in-flight access is
//   abandoned with no ack.
//  States: IDLE -> ACCESS -> DONE -> IDLE.
//  IDLE, arbitration: evaluated every cycle; no request -> stay in IDLE.
//   - If v_req and starve_cnt >= STARVE_MAX, display wins.
//   - Otherwise the winner is the first of d_req, f_req, v_req.
//   - On a win, register the winner's addr, we (fetch/display force we = 0) and wdata into
//     mem_* outputs, set gnt_id, and go to ACCESS.
//  starve_cnt: +1, saturating at 15, at each IDLE arbitration where v_req=1 and display loses.
//   Cleared to 0 when display is granted. Unchanged otherwise.
//  ACCESS: mem_addr and mem_wdata are held stable.
//   - Write: mem_we = 1 for exactly 1 cycle, then DONE.
//   - Read: mem_we = 0. Lasts RD_LAT+1 cycles, counted by a 3-bit counter. rdata <= mem_rdata
//     is captured at the final ACCESS edge, then DONE.
//  DONE: exactly one cycle. The granted *_ack = 1; rdata holds the captured value (unchanged
//   after a write). Next state IDLE. mem_we = 0.
//  Latency, request high in cycle 0 while IDLE:
//   - Write: mem_we in cycle 1, ack in cycle 2.
//   - Read: ack in cycle 2+RD_LAT.
//   - Back-to-back grants have 1 idle cycle between DONE and the next ACCESS.
//  Requester rules:
//   - Hold req, addr, we and wdata stable until ack is sampled.
//   - Deassert req at the edge where ack=1 is sampled; IDLE then sees req=0 and does not
//     re-grant.
//   - Changes to req or addr while not granted are ignored until arbitration.
//   - A non-granted requester may assert and deassert req freely in IDLE; there is no latch.
//  Simultaneous events: requests arriving in ACCESS or DONE wait for the next IDLE. Only one
//   *_ack is high in any cycle. rdata and mem_* hold their values between accesses.
//  Widths: all address/data paths are pass-through registers with no arithmetic.
// TESTING
//  1. Idle: all req=0 for 20 cycles -> busy=0, mem_we=0, all acks 0, gnt_id=0.
//  2. Fetch read, RD_LAT=1: f_req, f_addr=16'h0010 in cycle 0; mem_rdata=16'hABCD ->
//     mem_addr=16'h0010 in cycles 1-2, f_ack=1 and rdata=16'hABCD in cycle 3 only.
//  3. Store: d_req, d_we=1, d_addr=16'h8000, d_wdata=16'h1234 -> mem_we=1 only in cycle 1
//     with that addr/data, d_ack in cycle 2, rdata unchanged.
//  4. d, f, v requested together in cycle 0, each dropped on its ack -> service order
//     data, fetch, display; gnt_id sequence 1, 2, 3; one ack per DONE.
//  5. Starvation, STARVE_MAX=4: d_req and f_req re-asserted continuously, v_req held ->
//     v granted at its 5th arbitration; starve_cnt back to 0 afterwards.
//  6. Reset pulse mid-ACCESS of a store -> mem_we=0 immediately, no d_ack, busy=0. After
//     release, a new fetch completes with the normal latency.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the three memory requesters, the arbiter and the memory block.
// The arbiter side is the slave; the requester and memory side is the master.
interface mem_port_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
) ();
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          f_ack;
    logic          v_req;
    logic [AW-1:0] v_addr;
    logic          v_ack;
    logic [DW-1:0] rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic [1:0]    gnt_id;

    modport slave (
        input  d_req, d_we, d_addr, d_wdata, f_req, f_addr, v_req, v_addr, mem_rdata,
        output d_ack, f_ack, v_ack, rdata, mem_addr, mem_we, mem_wdata, busy, gnt_id
    );

    modport master (
        output d_req, d_we, d_addr, d_wdata, f_req, f_addr, v_req, v_addr, mem_rdata,
        input  d_ack, f_ack, v_ack, rdata, mem_addr, mem_we, mem_wdata, busy, gnt_id
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: data > fetch > display, with a starvation boost for display.
// One access in flight; every output is registered.
module mem_port_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [2:0] RD_LAT_C = 3'(RD_LAT);
    localparam logic [3:0] STARVE_C = 4'(STARVE_MAX);
    localparam logic [1:0] G_NONE   = 2'd0;
    localparam logic [1:0] G_DATA   = 2'd1;
    localparam logic [1:0] G_FETCH  = 2'd2;
    localparam logic [1:0] G_DISP   = 2'd3;

    state_t        state;
    logic [2:0]    lat_cnt;
    logic [3:0]    starve_cnt;
    logic          is_wr;
    logic [1:0]    gnt;
    logic [1:0]    win;
    logic          d_ack, f_ack, v_ack;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] rdata;

    // The starvation boost overrides the fixed priority order.
    always_comb begin
        win = G_NONE;
        if (bus.v_req && (starve_cnt >= STARVE_C)) win = G_DISP;
        else if (bus.d_req)                         win = G_DATA;
        else if (bus.f_req)                         win = G_FETCH;
        else if (bus.v_req)                         win = G_DISP;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            lat_cnt    <= 3'd0;
            starve_cnt <= 4'd0;
            is_wr      <= 1'b0;
            gnt        <= G_NONE;
            d_ack      <= 1'b0;
            f_ack      <= 1'b0;
            v_ack      <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rdata      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win == G_DISP)
                        starve_cnt <= 4'd0;
                    else if (bus.v_req && (starve_cnt != 4'hF))
                        starve_cnt <= starve_cnt + 4'd1;
                    if (win != G_NONE) begin
                        gnt     <= win;
                        lat_cnt <= 3'd0;
                        state   <= ACCESS;
                        case (win)
                            G_DATA: begin
                                mem_addr  <= bus.d_addr;
                                mem_wdata <= bus.d_wdata;
                                mem_we    <= bus.d_we;
                                is_wr     <= bus.d_we;
                            end
                            G_FETCH: begin
                                mem_addr <= bus.f_addr;
                                mem_we   <= 1'b0;
                                is_wr    <= 1'b0;
                            end
                            default: begin
                                mem_addr <= bus.v_addr;
                                mem_we   <= 1'b0;
                                is_wr    <= 1'b0;
                            end
                        endcase
                    end
                end
                ACCESS: begin
                    if (is_wr || (lat_cnt == RD_LAT_C)) begin
                        if (!is_wr) rdata <= bus.mem_rdata;
                        mem_we <= 1'b0;
                        d_ack  <= (gnt == G_DATA);
                        f_ack  <= (gnt == G_FETCH);
                        v_ack  <= (gnt == G_DISP);
                        state  <= DONE;
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                DONE: begin
                    d_ack <= 1'b0;
                    f_ack <= 1'b0;
                    v_ack <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.d_ack     = d_ack;
    assign bus.f_ack     = f_ack;
    assign bus.v_ack     = v_ack;
    assign bus.rdata     = rdata;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_we    = mem_we;
    assign bus.mem_wdata = mem_wdata;
    assign bus.busy      = (state != IDLE);
    assign bus.gnt_id    = gnt;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (RD_LAT=1, STARVE_MAX=4); the memory returns addr^A5A5
// unless a fixed read value is selected.
module tb_mem_port_arbiter;
    logic        clk         = 1'b0;
    logic        reset       = 1'b1;
    logic        rd_fixed_en = 1'b0;
    logic [15:0] rd_fixed    = 16'h0000;
    int          tests       = 0;
    int          fails       = 0;

    mem_port_arbiter_if #(.AW(16), .DW(16)) bus ();

    always_comb bus.mem_rdata = rd_fixed_en ? rd_fixed : (bus.mem_addr ^ 16'hA5A5);

    mem_port_arbiter #(.AW(16), .DW(16), .RD_LAT(1), .STARVE_MAX(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
        bus.f_req = 0; bus.f_addr = 0; bus.v_req = 0; bus.v_addr = 0;
        reset = 1'b1;
        #2;
        tests++;
        if ({bus.busy, bus.mem_we, bus.d_ack, bus.f_ack, bus.v_ack} !== 5'b0 || bus.gnt_id !== 2'd0 ||
            bus.mem_addr !== 16'h0 || bus.mem_wdata !== 16'h0 || bus.rdata !== 16'h0) begin
            fails++;
            $display("FAIL reset_state: busy=%b we=%b acks=%b%b%b gnt=%0d addr=%h wdata=%h rdata=%h, want all 0",
                     bus.busy, bus.mem_we, bus.d_ack, bus.f_ack, bus.v_ack, bus.gnt_id,
                     bus.mem_addr, bus.mem_wdata, bus.rdata);
        end
        step();
        reset = 1'b0;
    endtask

    task automatic test_idle();
        for (int c = 0; c < 20; c++) begin
            step();
            tests++;
            if (bus.busy !== 1'b0 || bus.mem_we !== 1'b0 || {bus.d_ack, bus.f_ack, bus.v_ack} !== 3'b0 ||
                bus.gnt_id !== 2'd0) begin
                fails++;
                $display("FAIL idle c%0d: busy=%b we=%b acks=%b%b%b gnt=%0d, want 0", c, bus.busy,
                         bus.mem_we, bus.d_ack, bus.f_ack, bus.v_ack, bus.gnt_id);
            end
        end
    endtask

    task automatic test_fetch_read();
        rd_fixed_en = 1'b1;
        rd_fixed    = 16'hABCD;
        bus.f_req   = 1'b1;
        bus.f_addr  = 16'h0010;
        for (int c = 1; c <= 4; c++) begin
            step();
            tests++;
            if (c <= 2 && (bus.mem_addr !== 16'h0010 || bus.f_ack !== 1'b0 || bus.busy !== 1'b1 ||
                           bus.gnt_id !== 2'd2 || bus.mem_we !== 1'b0)) begin
                fails++;
                $display("FAIL fetch_access c%0d: addr=%h ack=%b busy=%b gnt=%0d we=%b, want 0010 0 1 2 0",
                         c, bus.mem_addr, bus.f_ack, bus.busy, bus.gnt_id, bus.mem_we);
            end
            if (c == 3 && (bus.f_ack !== 1'b1 || bus.rdata !== 16'hABCD || bus.d_ack !== 1'b0 ||
                           bus.v_ack !== 1'b0)) begin
                fails++;
                $display("FAIL fetch_ack: f_ack=%b rdata=%h d/v_ack=%b%b, want 1 abcd 00",
                         bus.f_ack, bus.rdata, bus.d_ack, bus.v_ack);
            end
            if (c == 4 && (bus.f_ack !== 1'b0 || bus.busy !== 1'b0 || bus.gnt_id !== 2'd2)) begin
                fails++;
                $display("FAIL fetch_after: f_ack=%b busy=%b gnt=%0d, want 0 0 2",
                         bus.f_ack, bus.busy, bus.gnt_id);
            end
            if (c == 3) bus.f_req = 1'b0;
        end
        rd_fixed_en = 1'b0;
    endtask

    task automatic test_store();
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 16'h8000;
        bus.d_wdata = 16'h1234;
        for (int c = 1; c <= 3; c++) begin
            step();
            tests++;
            if (c == 1 && (bus.mem_we !== 1'b1 || bus.mem_addr !== 16'h8000 || bus.mem_wdata !== 16'h1234 ||
                           bus.d_ack !== 1'b0 || bus.gnt_id !== 2'd1)) begin
                fails++;
                $display("FAIL store_access: we=%b addr=%h wdata=%h ack=%b gnt=%0d, want 1 8000 1234 0 1",
                         bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.d_ack, bus.gnt_id);
            end
            if (c == 2 && (bus.mem_we !== 1'b0 || bus.d_ack !== 1'b1 || bus.rdata !== 16'hABCD)) begin
                fails++;
                $display("FAIL store_ack: we=%b ack=%b rdata=%h, want 0 1 abcd",
                         bus.mem_we, bus.d_ack, bus.rdata);
            end
            if (c == 3 && (bus.d_ack !== 1'b0 || bus.busy !== 1'b0 || bus.mem_addr !== 16'h8000 ||
                           bus.mem_wdata !== 16'h1234)) begin
                fails++;
                $display("FAIL store_after: ack=%b busy=%b addr=%h wdata=%h, want 0 0 8000 1234",
                         bus.d_ack, bus.busy, bus.mem_addr, bus.mem_wdata);
            end
            if (c == 2) begin
                bus.d_req = 1'b0;
                bus.d_we  = 1'b0;
            end
        end
    endtask

    task automatic test_priority();
        int order[$];
        int ackcyc[$];
        bit multi = 0;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 16'h0040;
        bus.f_req = 1; bus.f_addr = 16'h0020;
        bus.v_req = 1; bus.v_addr = 16'h0030;
        for (int c = 1; c <= 16; c++) begin
            step();
            if ((int'(bus.d_ack) + int'(bus.f_ack) + int'(bus.v_ack)) > 1) multi = 1;
            if (bus.d_ack || bus.f_ack || bus.v_ack) begin
                logic [15:0] exp_rd;
                logic [1:0]  exp_g;
                if (bus.d_ack)      begin exp_g = 2'd1; exp_rd = 16'h0040 ^ 16'hA5A5; bus.d_req = 0; end
                else if (bus.f_ack) begin exp_g = 2'd2; exp_rd = 16'h0020 ^ 16'hA5A5; bus.f_req = 0; end
                else                begin exp_g = 2'd3; exp_rd = 16'h0030 ^ 16'hA5A5; bus.v_req = 0; end
                order.push_back(int'(exp_g));
                ackcyc.push_back(c);
                tests++;
                if (bus.gnt_id !== exp_g || bus.rdata !== exp_rd) begin
                    fails++;
                    $display("FAIL prio_ack c%0d: gnt=%0d rdata=%h, want %0d %h",
                             c, bus.gnt_id, bus.rdata, exp_g, exp_rd);
                end
            end
        end
        tests++;
        if (multi) begin
            fails++;
            $display("FAIL prio_one_ack: more than one ack seen in a cycle, want exactly one");
        end
        tests++;
        if (order.size() != 3 || order[0] != 1 || order[1] != 2 || order[2] != 3) begin
            fails++;
            $display("FAIL prio_order: got %p, want '{1,2,3}", order);
        end
        tests++;
        if (ackcyc.size() != 3 || ackcyc[0] != 3 || ackcyc[1] != 7 || ackcyc[2] != 11) begin
            fails++;
            $display("FAIL prio_timing: ack cycles %p, want '{3,7,11}", ackcyc);
        end
        bus.d_req = 0; bus.f_req = 0; bus.v_req = 0;
        step();
    endtask

    task automatic test_starvation();
        int dsince = 0;
        int fcount = 0;
        int vcount = 0;
        int dbefore[2];
        bit reassert = 0;
        dbefore[0] = -1;
        dbefore[1] = -1;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 16'h0100;
        bus.f_req = 1; bus.f_addr = 16'h0200;
        bus.v_req = 1; bus.v_addr = 16'h0300;
        for (int c = 1; c <= 200 && vcount < 2; c++) begin
            step();
            if (bus.d_ack) dsince++;
            if (bus.f_ack) fcount++;
            if (bus.v_ack) begin
                tests++;
                if (bus.rdata !== (16'h0300 ^ 16'hA5A5) || bus.gnt_id !== 2'd3) begin
                    fails++;
                    $display("FAIL starve_vdata: rdata=%h gnt=%0d, want %h 3",
                             bus.rdata, bus.gnt_id, 16'h0300 ^ 16'hA5A5);
                end
                dbefore[vcount] = dsince;
                dsince = 0;
                vcount++;
                bus.v_req = 0;
                reassert = (vcount < 2);
                if (vcount == 2) begin
                    bus.d_req = 0;
                    bus.f_req = 0;
                end
            end else if (reassert) begin
                bus.v_req = 1;
                reassert  = 0;
            end
        end
        tests++;
        if (vcount != 2) begin
            fails++;
            $display("FAIL starve_timeout: display granted %0d times in 200 cycles, want 2", vcount);
        end
        tests++;
        if (dbefore[0] != 4) begin
            fails++;
            $display("FAIL starve_first: %0d data grants before display, want 4", dbefore[0]);
        end
        tests++;
        if (dbefore[1] != 4) begin
            fails++;
            $display("FAIL starve_cleared: %0d data grants before second display, want 4", dbefore[1]);
        end
        tests++;
        if (fcount != 0) begin
            fails++;
            $display("FAIL starve_fetch: fetch granted %0d times, want 0", fcount);
        end
        step();
        step();
    endtask

    task automatic test_reset_mid_access();
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 16'h8002; bus.d_wdata = 16'h5555;
        step();
        tests++;
        if (bus.mem_we !== 1'b1 || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL rst_pre: we=%b busy=%b, want 1 1", bus.mem_we, bus.busy);
        end
        reset = 1'b1;
        #1;
        tests++;
        if (bus.mem_we !== 1'b0 || bus.busy !== 1'b0 || bus.gnt_id !== 2'd0 || bus.mem_addr !== 16'h0) begin
            fails++;
            $display("FAIL rst_async: we=%b busy=%b gnt=%0d addr=%h, want 0 0 0 0000",
                     bus.mem_we, bus.busy, bus.gnt_id, bus.mem_addr);
        end
        bus.d_req = 0; bus.d_we = 0;
        step();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            tests++;
            if (bus.d_ack !== 1'b0 || bus.busy !== 1'b0 || bus.mem_we !== 1'b0) begin
                fails++;
                $display("FAIL rst_noack c%0d: d_ack=%b busy=%b we=%b, want 0 0 0",
                         c, bus.d_ack, bus.busy, bus.mem_we);
            end
        end
        bus.f_req  = 1;
        bus.f_addr = 16'h0044;
        for (int c = 1; c <= 4; c++) begin
            step();
            tests++;
            if (bus.f_ack !== (c == 3) || (c == 3 && bus.rdata !== (16'h0044 ^ 16'hA5A5))) begin
                fails++;
                $display("FAIL rst_fetch c%0d: f_ack=%b rdata=%h, want %b %h",
                         c, bus.f_ack, bus.rdata, (c == 3), 16'h0044 ^ 16'hA5A5);
            end
            if (c == 3) bus.f_req = 0;
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_fetch_read();
        test_store();
        test_priority();
        test_starvation();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish, want completion");
        $fatal(1, "timeout");
    end
endmodule
